spi_byte_bridge: RTL
====================

SPI_BYTE_BRIDGE -- requirements
Module: spi_byte_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width of both FIFOs and the master data bus.
REQ-002 SHALL have parameter DEPTH, default 8, entries per FIFO; power of two, >=2.
REQ-003 SHALL have a single clock and a synchronous, active-high reset.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 wr_data  in  DATA_WIDTH  host byte to transmit.
REQ-007 wr_en  in  1  push wr_data into TX FIFO.
REQ-008 tx_full  out  1  TX FIFO holds DEPTH entries.
REQ-009 tx_level  out  $clog2(DEPTH)+1  TX FIFO occupancy.
REQ-010 rd_en  in  1  pop RX FIFO head.
REQ-011 rd_data  out  DATA_WIDTH  RX FIFO head, first-word-fall-through.
REQ-012 rx_empty  out  1  RX FIFO holds 0 entries.
REQ-013 rx_level  out  $clog2(DEPTH)+1  RX FIFO occupancy.
REQ-014 m_tx_data  out  DATA_WIDTH  byte to SPI master.
REQ-015 m_tx_valid  out  1  byte offered to SPI master.
REQ-016 m_tx_ready  in  1  SPI master accepts byte.
REQ-017 m_rx_data  in  DATA_WIDTH  byte received by SPI master.
REQ-018 m_rx_valid  in  1  one-cycle strobe, m_rx_data valid.
REQ-019 busy  out  1  FSM not in IDLE.
REQ-020 tx_ovf, rx_ovf  out  1 each  sticky overflow flags.
REQ-021 ovf_clr  in  1  clear both overflow flags.

Function
REQ-022 FSM states SHALL be IDLE, ISSUE, WAIT_RX.
REQ-023 IDLE->ISSUE SHALL occur on the cycle after TX FIFO becomes non-empty; otherwise the FSM SHALL remain in IDLE.
REQ-024 In ISSUE, m_tx_valid SHALL be 1 and m_tx_data SHALL equal the TX FIFO head, held stable until handshake.
REQ-025 On m_tx_valid&&m_tx_ready, the TX head SHALL be popped and the FSM SHALL go to WAIT_RX; m_tx_valid SHALL be 0 the next cycle.
REQ-026 In WAIT_RX, on m_rx_valid, m_rx_data SHALL be pushed to the RX FIFO; next state SHALL be ISSUE if TX FIFO is non-empty, else IDLE.
REQ-027 m_rx_valid outside WAIT_RX SHALL be ignored: no push, no flag.
REQ-028 m_tx_valid SHALL be 0 in IDLE and WAIT_RX; exactly one byte SHALL be outstanding at a time.
REQ-029 wr_en with tx_full=1 SHALL drop the byte, even if a pop occurs the same cycle.
REQ-030 An RX push with RX FIFO full SHALL be accepted if rd_en is 1 that cycle; otherwise the byte SHALL be dropped.
REQ-031 rd_en with rx_empty=1 SHALL be ignored; a simultaneous push and pop on a non-full FIFO SHALL leave the level unchanged.
REQ-032 FIFO pointers SHALL wrap modulo DEPTH; levels SHALL be saturation-free in the range 0..DEPTH.
REQ-033 rd_data SHALL update the cycle after a push into an empty RX FIFO.

Reset
REQ-034 rst SHALL force FSM to IDLE, both FIFOs empty, and clear tx_ovf and rx_ovf, including mid-transfer; an m_rx_valid in the reset cycle SHALL be discarded.
REQ-035 Reset values: m_tx_valid=0, m_tx_data=0, busy=0, tx_full=0, tx_level=0, rx_empty=1, rx_level=0, rd_data=0, tx_ovf=0, rx_ovf=0.

Configuration
REQ-036 Macro SPI_BYTE_BRIDGE_OVF_EN SHALL control the overflow flags.
REQ-037 With SPI_BYTE_BRIDGE_OVF_EN defined, a drop per REQ-029 SHALL set tx_ovf and a drop per REQ-030 SHALL set rx_ovf; ovf_clr SHALL clear both, and a same-cycle set SHALL win over clear.
REQ-038 Without SPI_BYTE_BRIDGE_OVF_EN, tx_ovf and rx_ovf SHALL be constant 0, ovf_clr SHALL be ignored, and drop behaviour SHALL be unchanged.

Verification
REQ-039 Single byte: write 0xA5, master echoes 0x3C -> m_tx_data=0xA5 in ISSUE; rx_level=1, rd_data=0x3C; busy returns to 0.
REQ-040 Burst: write 0x01..0x08 back-to-back -> tx_full=1 after 8th; 8 handshakes in order 0x01..0x08; no idle gap between WAIT_RX and ISSUE.
REQ-041 TX overflow: 9 writes with m_tx_ready=0 -> tx_level=8, 9th dropped, tx_ovf=1 (macro on) or 0 (macro off); ovf_clr -> tx_ovf=0.
REQ-042 RX full: 9 transfers, no rd_en -> rx_level=8, 9th dropped, rx_ovf=1; repeat with rd_en on the 9th push -> accepted, rx_ovf stays 0.
REQ-043 Reset mid-operation: rst asserted in WAIT_RX with 3 bytes queued -> next cycle IDLE, all levels 0, m_tx_valid=0; a subsequent stray m_rx_valid does not push.
REQ-044 Stray strobe: m_rx_valid=1 in IDLE with data 0xFF -> rx_level stays 0, rx_ovf stays 0.

Source files
------------

// File: rtl/spi_byte_bridge.sv
// Host byte FIFOs bridged to a single-outstanding-byte SPI master handshake.
// Latency: TX byte offered 2 cycles after a write into an idle bridge; received byte readable 1 cycle after its strobe.
// Backpressure: host writes dropped while TX full; master bytes dropped while RX full unless read that cycle.
// Optional sticky overflow flags enabled by defining SPI_BYTE_BRIDGE_OVF_EN.

module spi_byte_bridge_fifo #(
    parameter int DW        = 8,
    parameter int DEPTH     = 8,
    parameter bit PASS_FULL = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DW-1:0]          push_dat,
    input  logic                   pop,
    output logic [DW-1:0]          head_dat,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic                   drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] CNT_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          pop_ok;
    logic          push_ok;

    assign empty    = (count == '0);
    assign full     = (count == FULL_LVL);
    assign level    = count;
    assign pop_ok   = pop && !empty;
    // PASS_FULL lets a push into a full FIFO land in the slot freed by a same-cycle pop.
    assign push_ok  = push && (!full || (PASS_FULL && pop_ok));
    assign drop     = push && !push_ok;
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

module spi_byte_bridge #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   wr_en,
    output logic                   tx_full,
    output logic [$clog2(DEPTH):0] tx_level,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rx_empty,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic [DATA_WIDTH-1:0]  m_tx_data,
    output logic                   m_tx_valid,
    input  logic                   m_tx_ready,
    input  logic [DATA_WIDTH-1:0]  m_rx_data,
    input  logic                   m_rx_valid,
    output logic                   busy,
    output logic                   tx_ovf,
    output logic                   rx_ovf,
    input  logic                   ovf_clr
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT_RX = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [DATA_WIDTH-1:0] tx_head;
    logic                  tx_empty;
    logic                  tx_pop;
    logic                  tx_drop;
    logic                  rx_push;
    logic                  rx_drop;
    logic                  rx_full_unused;

    assign m_tx_valid = (state == ISSUE);
    assign m_tx_data  = m_tx_valid ? tx_head : '0;
    assign busy       = (state != IDLE);
    assign tx_pop     = m_tx_valid && m_tx_ready;
    // Strobes arriving outside WAIT_RX do not belong to an outstanding byte.
    assign rx_push    = (state == WAIT_RX) && m_rx_valid;

    spi_byte_bridge_fifo #(
        .DW        (DATA_WIDTH),
        .DEPTH     (DEPTH),
        .PASS_FULL (1'b0)
    ) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_en),
        .push_dat (wr_data),
        .pop      (tx_pop),
        .head_dat (tx_head),
        .level    (tx_level),
        .full     (tx_full),
        .empty    (tx_empty),
        .drop     (tx_drop)
    );

    spi_byte_bridge_fifo #(
        .DW        (DATA_WIDTH),
        .DEPTH     (DEPTH),
        .PASS_FULL (1'b1)
    ) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rx_push),
        .push_dat (m_rx_data),
        .pop      (rd_en),
        .head_dat (rd_data),
        .level    (rx_level),
        .full     (rx_full_unused),
        .empty    (rx_empty),
        .drop     (rx_drop)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!tx_empty) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (m_tx_ready) begin
                    state_nxt = WAIT_RX;
                end
            end
            WAIT_RX: begin
                // Chain straight into the next byte so bursts have no idle gap.
                if (m_rx_valid) begin
                    state_nxt = tx_empty ? IDLE : ISSUE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef SPI_BYTE_BRIDGE_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (tx_drop) begin
                tx_ovf <= 1'b1;
            end else if (ovf_clr) begin
                tx_ovf <= 1'b0;
            end
            if (rx_drop) begin
                rx_ovf <= 1'b1;
            end else if (ovf_clr) begin
                rx_ovf <= 1'b0;
            end
        end
    end
`else
    logic ovf_unused;
    assign ovf_unused = ^{ovf_clr, tx_drop, rx_drop};
    assign tx_ovf     = 1'b0;
    assign rx_ovf     = 1'b0;
`endif
endmodule
